// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and PS/2 pin signals for ps2_host_tx.
//   tx_start/tx_data           : command request and byte to send
//   tx_busy/tx_done/tx_err     : transfer status
//   ps2_clk_i/ps2_data_i       : raw pin levels (asynchronous)
//   ps2_clk_oe/ps2_data_oe     : open-drain pull-low enables (1 = drive low)
// master: command issuer plus pad side; slave: the transmitter.
interface ps2_host_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_start, tx_data, ps2_clk_i, ps2_data_i,
    input  tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_start, tx_data, ps2_clk_i, ps2_data_i,
    output tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Inhibits the clock, issues
// request-to-send, then shifts out start, 8 data bits (LSB first), odd parity
// and stop on device clock falls, samples the device ACK and reports
// completion. Lines are driven open-drain via active-high pull-low enables.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : ps2_host_tx_if.slave (tx_start, tx_data, tx_busy, tx_done, tx_err,
//          ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe)
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus
);

  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          clk_s;
  logic          data_s;
  logic          clk_fall;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          ack;
  logic          clk_oe_q;
  logic          data_oe_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign clk_fall = clk_prev & ~clk_s;

  // Synchronizers idle high so reset never manufactures a clock fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], bus.ps2_clk_i};
      data_sync <= {data_sync[0], bus.ps2_data_i};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      ack       <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.tx_start) begin
            // {stop, odd parity, data}
            shreg    <= {1'b1, ~^bus.tx_data, bus.tx_data};
            inh_cnt  <= '0;
            clk_oe_q <= 1'b1;
            busy_q   <= 1'b1;
            state    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;
            state     <= S_RTS;
          end else begin
            inh_cnt <= inh_cnt + IW'(1);
          end
        end

        S_RTS: begin
          bit_cnt <= '0;
          to_cnt  <= '0;
          state   <= S_SEND;
        end

        S_SEND: begin
          if (clk_fall) begin
            to_cnt  <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd10) begin
              ack   <= data_s;
              state <= S_WAIT_IDLE;
            end else begin
              // Falls 1..10 present data, parity, then the stop bit (released).
              data_oe_q <= ~shreg[bit_cnt];
            end
          end else if (to_cnt == TMO_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state     <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        S_WAIT_IDLE: begin
          if (clk_s && data_s) begin
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= ack;
            state     <= S_DONE;
          end else if (clk_fall) begin
            to_cnt <= '0;
          end else if (to_cnt == TMO_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state     <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_err      = err_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (LED set, typematic rate, reset, etc.) from the FPGA to an attached PS/2 keyboard or mouse, using the device-clocked host-to-device frame. Sits beside `ps2_scanner`, which receives device-to-host traffic on the same two pins. The block drives the open-drain lines through active-high output enables: 1 pulls the line low, 0 releases it. It reports completion, acknowledge status and timeout.

## Interface
- `INHIBIT_CYCLES`, 10000: `clk` cycles `ps2_clk` is held low before request-to-send (≥100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 1500000: maximum `clk` cycles allowed between consecutive device clock falls, including RTS to the first fall.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `tx_start`  in  1  single-cycle request; `tx_data` is captured when `tx_start` is seen in IDLE.
- `tx_data`  in  8  byte to send.
- `ps2_clk_i`  in  1  raw PS/2 clock pin level (asynchronous).
- `ps2_data_i`  in  1  raw PS/2 data pin level (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull PS/2 clock low.
- `ps2_data_oe`  out  1  1 = pull PS/2 data low.
- `tx_busy`  out  1  high from the cycle after the accepted start until the cycle of `tx_done`.
- `tx_done`  out  1  one-cycle completion pulse.
- `tx_err`  out  1  valid with `tx_done`: 1 = no acknowledge or timeout.

## Operation
- Inputs pass through 2-FF synchronizers. A falling edge is detected when the synchronized clock goes from 1 to 0.
- The shift register holds {stop=1, parity, tx_data[7:0]}. Parity is odd: the complement of the XOR-reduction of `tx_data`.
- States:
  - IDLE: all outputs 0. `tx_start` captures the byte and goes to INHIBIT. `tx_start` in any other state is ignored.
  - INHIBIT: `ps2_clk_oe`=1 for exactly `INHIBIT_CYCLES` cycles, then go to RTS.
  - RTS: `ps2_clk_oe`=0 and `ps2_data_oe`=1 (start bit 0) in the same cycle. Bit counter = 0. Timeout counter is cleared. Move to SEND.
  - SEND: on each falling edge, the counter increments.
    - Falls 1..8: `ps2_data_oe` = ~tx_data[n-1], LSB first.
    - Fall 9: `ps2_data_oe` = ~parity.
    - Fall 10: `ps2_data_oe`=0 (stop bit, line released).
    - Fall 11: sample synchronized data into the ACK bit. 0 means acknowledged. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then go to DONE.
  - DONE: `tx_done`=1 for one cycle, `tx_err` = ACK bit, then return to IDLE.
- Timeout:
  - The timeout counter runs in SEND and WAIT_IDLE and resets on every falling edge.
  - Reaching `TIMEOUT_CYCLES` releases both lines and goes to DONE with `tx_err`=1.
- Reset: any state goes to IDLE; all outputs and counters are cleared.

## Timing
- Reset value of every output is 0: `ps2_clk_oe`, `ps2_data_oe`, `tx_busy`, `tx_done`, `tx_err`.
- Start to clock inhibit: `ps2_clk_oe` rises 1 cycle after the `tx_start` cycle. `tx_busy` rises in the same cycle.
- `ps2_clk_oe` stays high for exactly `INHIBIT_CYCLES`. In the following cycle, `ps2_clk_oe`=0 and `ps2_data_oe`=1.
- Pin fall to data update: `ps2_data_oe` updates 3 `clk` cycles after the `ps2_clk_i` pin fall (2 sync + 1 register). This is well inside the device's half-period of ≥30 µs.
- `tx_done` is asserted a minimum of 3 cycles after both pins return high. `tx_busy` deasserts in the `tx_done` cycle.
- Back-to-back: a `tx_start` in the cycle after `tx_done` is accepted. A `tx_start` coincident with `tx_done` is ignored.
- Synchronous reset mid-frame: both OEs are 0 on the cycle after `rst` is sampled high. No `tx_done` is produced.

## Test plan
- Use `INHIBIT_CYCLES`=100 and `TIMEOUT_CYCLES`=2000 in the bench. The bench models the device: it generates ~25-cycle clock half-periods after it sees RTS, samples data on the rising edges, and drives ACK low on fall 11.
- Send 0xED: expected data after the start bit is 1,0,1,1,0,1,1,1, parity 1, stop 1. ACK is given → `tx_done`=1, `tx_err`=0. `ps2_clk_oe` high for exactly 100 cycles.
- Send 0xF4 (popcount 5): parity bit 0. Then send 0x00 (parity 1) back-to-back in the cycle after `tx_done`; both frames are correct.
- Device never drives ACK (data stays high at fall 11) → `tx_done`=1 with `tx_err`=1. Both OEs are 0.
- Device stops clocking after fall 4 → `tx_done`/`tx_err`=1 exactly 2000 cycles after the last fall. Both lines are released.
- Assert `rst` during SEND at fall 6 → OEs are 0 next cycle, no `tx_done`. A new `tx_start` with 0xED afterwards completes cleanly.
- `tx_start` pulsed while `tx_busy`=1 → ignored; the frame in flight carries only the original byte.
